// File: rtl/wb_select_stage.sv
// Registered writeback selector: picks one result source, extracts/extends loads, and hands
// {data, rd, we} to the register file through a valid/ready stage with a 2-entry skid buffer.
// Optional WB_STALL_CNT_EN adds a 16-bit saturating count of stalled output cycles (stall_cnt).
module wb_select_stage #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned NSRC      = 4,
    parameter int unsigned MEM_SRC   = 1,
    parameter int unsigned REGADDR_W = 5,
    localparam int unsigned SEL_W    = $clog2(NSRC),
    localparam int unsigned OFF_W    = $clog2(DATA_W / 8)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [SEL_W-1:0]       in_sel,
    input  logic [NSRC*DATA_W-1:0] in_data,
    input  logic [1:0]             in_lsize,
    input  logic                   in_lunsigned,
    input  logic [OFF_W-1:0]       in_byte_off,
    input  logic [REGADDR_W-1:0]   in_rd,
    input  logic                   in_we,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_W-1:0]      out_data,
    output logic [REGADDR_W-1:0]   out_rd,
    output logic                   out_we
`ifdef WB_STALL_CNT_EN
    ,
    output logic [15:0]            stall_cnt
`endif
);

    logic [DATA_W-1:0]    src_sel_c;
    logic [DATA_W-1:0]    lane_c;
    logic [DATA_W-1:0]    new_data_c;
    logic                 new_we_c;
    logic                 accept_c;
    logic                 main_free_c;

    logic                 out_valid_q, out_valid_d;
    logic [DATA_W-1:0]    out_data_q, out_data_d;
    logic [REGADDR_W-1:0] out_rd_q, out_rd_d;
    logic                 out_we_q, out_we_d;
    logic                 skid_valid_q, skid_valid_d;
    logic [DATA_W-1:0]    skid_data_q, skid_data_d;
    logic [REGADDR_W-1:0] skid_rd_q, skid_rd_d;
    logic                 skid_we_q, skid_we_d;
    logic                 in_ready_q, in_ready_d;

    // Source select plus load lane extraction when the memory source is chosen.
    always_comb begin
        src_sel_c = '0;
        for (int k = 0; k < int'(NSRC); k++) begin
            if (in_sel == SEL_W'(k)) src_sel_c = in_data[k*DATA_W +: DATA_W];
        end
        lane_c     = src_sel_c >> {in_byte_off, 3'b000};
        new_data_c = src_sel_c;
        if (in_sel == SEL_W'(MEM_SRC)) begin
            case (in_lsize)
                2'b00: begin
                    if (in_lunsigned) new_data_c = DATA_W'(lane_c[7:0]);
                    else              new_data_c = DATA_W'($signed(lane_c[7:0]));
                end
                2'b01: begin
                    if (in_lunsigned) new_data_c = DATA_W'(lane_c[15:0]);
                    else              new_data_c = DATA_W'($signed(lane_c[15:0]));
                end
                2'b10: begin
                    if (in_lunsigned) new_data_c = DATA_W'(lane_c[31:0]);
                    else              new_data_c = DATA_W'($signed(lane_c[31:0]));
                end
                default: new_data_c = src_sel_c;
            endcase
        end
        new_we_c = in_we && (in_rd != '0);
    end

    // Main/skid steering; skid drains into main on transfer, new data bypasses skid when main is free.
    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_rd_d     = out_rd_q;
        out_we_d     = out_we_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        skid_rd_d    = skid_rd_q;
        skid_we_d    = skid_we_q;
        accept_c     = in_valid && in_ready_q;
        main_free_c  = !out_valid_q || out_ready;

        if (main_free_c) begin
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_data_d   = skid_data_q;
                out_rd_d     = skid_rd_q;
                out_we_d     = skid_we_q;
                skid_valid_d = 1'b0;
            end else if (accept_c) begin
                out_valid_d = 1'b1;
                out_data_d  = new_data_c;
                out_rd_d    = in_rd;
                out_we_d    = new_we_c;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (accept_c) begin
            skid_valid_d = 1'b1;
            skid_data_d  = new_data_c;
            skid_rd_d    = in_rd;
            skid_we_d    = new_we_c;
        end
        in_ready_d = !skid_valid_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_rd_q     <= '0;
            out_we_q     <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_rd_q    <= '0;
            skid_we_q    <= 1'b0;
            in_ready_q   <= 1'b1;
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_rd_q     <= out_rd_d;
            out_we_q     <= out_we_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            skid_rd_q    <= skid_rd_d;
            skid_we_q    <= skid_we_d;
            in_ready_q   <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_rd    = out_rd_q;
    assign out_we    = out_we_q;

`ifdef WB_STALL_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    // Saturating count of cycles the output is held by downstream backpressure.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (out_valid_q && !out_ready && (stall_cnt_q != 16'hFFFF)) stall_cnt_d = stall_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stall_cnt_q <= '0;
        else        stall_cnt_q <= stall_cnt_d;
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule
